// File: rtl/otp_digit_sender.sv
// Plays a captured code out as a sequence of 4-bit digits, MSB nibble first,
// each qualified by a registered one-cycle latch strobe for the OTP entry FSM.
module otp_digit_sender #(
  parameter int DIGITS       = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int GAP_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*4-1:0]   code_in,
  input  logic                  start,
  input  logic                  abort,
  output logic [3:0]            digit_out,
  output logic                  digit_latch,
  output logic                  busy,
  output logic                  done
);

  localparam int CODE_W  = DIGITS * 4;
  localparam int CNT_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LATCH,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [CODE_W-1:0]   shift_next;
  logic [3:0]          digit_q, digit_d;
  logic                latch_q, latch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Top nibble of the shift register is always the digit currently on the bus.
  assign shift_next = shift_q << 4;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    digit_d = digit_q;
    latch_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (abort) begin
      // Abort wins over start and over a pending done; the bus is parked at zero.
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = '0;
      digit_d = 4'h0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SETUP;
            shift_d = code_in;
            digit_d = code_in[CODE_W-1 -: 4];
            busy_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = SETUP_LOAD;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_d = S_LATCH;
            latch_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_LATCH: begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_SETUP;
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_next;
            digit_d = shift_next[CODE_W-1 -: 4];
            cnt_d   = SETUP_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      digit_q <= 4'h0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      digit_q <= digit_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign digit_out   = digit_q;
  assign digit_latch = latch_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_otp_digit_sender.sv
// Bench for otp_digit_sender: a timeline model of each transfer (offset from the
// accepted start) checked every cycle, plus directed scenarios with literal values.
module tb_otp_digit_sender;

  localparam int DIGITS = 4;
  localparam int SETUP  = 2;
  localparam int GAP    = 3;
  localparam int PERIOD = SETUP + 1 + GAP;
  localparam int TOTAL  = DIGITS * (SETUP + 1) + (DIGITS - 1) * GAP + 1;

  logic        clk;
  logic        reset;
  logic [15:0] code_in;
  logic        start;
  logic        abort;
  logic [3:0]  digit_out;
  logic        digit_latch;
  logic        busy;
  logic        done;

  otp_digit_sender #(
    .DIGITS(DIGITS),
    .SETUP_CYCLES(SETUP),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .code_in(code_in),
    .start(start),
    .abort(abort),
    .digit_out(digit_out),
    .digit_latch(digit_latch),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_num = 0;
  int base = 0;

  // Reference: a transfer is just "time since accepted start" plus the captured code.
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [15:0] m_code = '0;
  logic [3:0]  m_digit = '0;
  bit          m_busy = 1'b0;
  bit          m_latch = 1'b0;
  bit          m_done = 1'b0;

  int          strobe_rel[$];
  logic [3:0]  strobe_dig[$];
  int          done_count = 0;
  bit          prev_latch = 1'b0;
  logic [3:0]  prev_digit = '0;

  function automatic logic [3:0] nib(input logic [15:0] c, input int n);
    return c[15-4*n -: 4];
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input logic [15:0] code);
    start   = st;
    abort   = ab;
    code_in = code;
  endtask

  task automatic modelOutputs();
    int n;
    if (m_t >= TOTAL) begin
      m_active = 1'b0;
      m_busy   = 1'b0;
      m_latch  = 1'b0;
      m_done   = 1'b0;
      m_digit  = nib(m_code, DIGITS - 1);
    end else begin
      n = m_t / PERIOD;
      m_busy  = 1'b1;
      m_digit = nib(m_code, (n > DIGITS - 1) ? DIGITS - 1 : n);
      m_latch = ((m_t % PERIOD) == SETUP) && (n < DIGITS);
      m_done  = (m_t == TOTAL - 1);
    end
  endtask

  always @(posedge clk) edge_num++;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_digit  = '0;
      m_busy   = 1'b0;
      m_latch  = 1'b0;
      m_done   = 1'b0;
    end else if (abort) begin
      m_active = 1'b0;
      m_digit  = '0;
      m_busy   = 1'b0;
      m_latch  = 1'b0;
      m_done   = 1'b0;
    end else if (m_active) begin
      m_t++;
      modelOutputs();
    end else if (start) begin
      m_active = 1'b1;
      m_t      = 0;
      m_code   = code_in;
      modelOutputs();
    end else begin
      m_latch = 1'b0;
      m_done  = 1'b0;
    end
  end

  // Every-cycle compare against the model, plus the strobe invariants and a strobe log.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("digit_out", digit_out, m_digit);
      checkOutput("digit_latch", digit_latch, m_latch);
      checkOutput("busy", busy, m_busy);
      checkOutput("done", done, m_done);
      checkOutput("latch twice", digit_latch && prev_latch, 0);
      checkOutput("latch outside busy", digit_latch && !busy, 0);
      checkOutput("digit moved on latch", digit_latch && (digit_out != prev_digit), 0);
      if (digit_latch) begin
        strobe_rel.push_back(edge_num - base);
        strobe_dig.push_back(digit_out);
      end
      if (done) done_count++;
    end
    prev_latch = digit_latch;
    prev_digit = digit_out;
  end

  task automatic clearLogs();
    strobe_rel.delete();
    strobe_dig.delete();
    done_count = 0;
  endtask

  task automatic waitRel(input int r);
    for (int i = 0; i < 200 && (edge_num - base) < r; i++) @(negedge clk);
    checkOutput("edge reached", edge_num - base, r);
  endtask

  task automatic waitIdle();
    int i;
    for (i = 0; i < 200 && busy; i++) @(negedge clk);
    checkOutput("idle timeout", busy, 0);
  endtask

  task automatic checkStrobe(input int i, input int rel, input int dig);
    if (strobe_rel.size() > i) begin
      checkOutput("strobe edge", strobe_rel[i], rel);
      checkOutput("strobe digit", strobe_dig[i], dig);
    end else begin
      checkOutput("strobe missing", i, -1);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 16'h0000);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset digit", digit_out, 0);
    checkOutput("reset latch", digit_latch, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 16'h1234 with ignored starts at edges 5, 21 and 22 (DONE cycle).
    clearLogs();
    applyStimulus(1, 0, 16'h1234);
    base = edge_num + 1;
    waitRel(0);
    applyStimulus(0, 0, 16'hFFFF);
    waitRel(4);
    applyStimulus(1, 0, 16'hFFFF);
    waitRel(5);
    applyStimulus(0, 0, 16'hFFFF);
    waitRel(20);
    applyStimulus(1, 0, 16'hFFFF);
    waitRel(21);
    checkOutput("done at 21", done, 1);
    checkOutput("busy at 21", busy, 1);
    waitRel(22);
    checkOutput("busy at 22", busy, 0);
    checkOutput("done at 22", done, 0);
    checkOutput("held digit", digit_out, 4);
    waitRel(23);
    checkOutput("restart busy", busy, 1);
    checkOutput("restart digit", digit_out, 15);
    applyStimulus(0, 0, 16'h0000);
    checkOutput("1234 strobes", strobe_rel.size(), 4);
    checkStrobe(0, 2, 1);
    checkStrobe(1, 8, 2);
    checkStrobe(2, 14, 3);
    checkStrobe(3, 20, 4);
    checkOutput("1234 dones", done_count, 1);
    waitIdle();

    // Hex nibbles pass through untouched.
    clearLogs();
    applyStimulus(1, 0, 16'h9A0F);
    base = edge_num + 1;
    waitRel(0);
    applyStimulus(0, 0, 16'h0000);
    waitIdle();
    checkOutput("9A0F strobes", strobe_rel.size(), 4);
    checkStrobe(0, 2, 9);
    checkStrobe(1, 8, 10);
    checkStrobe(2, 14, 0);
    checkStrobe(3, 20, 15);
    checkOutput("9A0F dones", done_count, 1);

    // Abort at edge 10, restart at edge 11.
    clearLogs();
    applyStimulus(1, 0, 16'h1234);
    base = edge_num + 1;
    waitRel(0);
    applyStimulus(0, 0, 16'h0000);
    waitRel(9);
    applyStimulus(0, 1, 16'h0000);
    waitRel(10);
    checkOutput("abort digit", digit_out, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort strobes", strobe_rel.size(), 2);
    checkStrobe(0, 2, 1);
    checkStrobe(1, 8, 2);
    checkOutput("abort no done", done_count, 0);
    applyStimulus(1, 0, 16'h1234);
    waitRel(11);
    applyStimulus(0, 0, 16'h0000);
    checkOutput("post-abort busy", busy, 1);
    checkOutput("post-abort digit", digit_out, 1);
    waitIdle();
    checkOutput("post-abort strobes", strobe_rel.size(), 6);
    checkOutput("post-abort dones", done_count, 1);

    // Async reset in the middle of SETUP; nothing resumes afterwards.
    applyStimulus(1, 0, 16'hABCD);
    base = edge_num + 1;
    waitRel(1);
    applyStimulus(0, 0, 16'h0000);
    checkOutput("pre-reset busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async digit", digit_out, 0);
    checkOutput("async busy", busy, 0);
    checkOutput("async latch", digit_latch, 0);
    checkOutput("async done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("no resume busy", busy, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(3) == 0, $urandom_range(59) == 0, 16'($urandom));
      @(negedge clk);
    end
    applyStimulus(0, 0, 16'h0000);
    waitIdle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
